keccak_rhopi_pipe: RTL
======================

KECCAK_RHOPI_PIPE -- requirements
Module: keccak_rhopi_pipe

Interface
REQ-001 SHALL have parameter W, default 8, meaning lane width in bits, legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 SHALL have parameter SHARES, default 3, meaning number of Boolean shares, legal range 1..8.
REQ-003 SHALL have port ClkxCI, input, 1, single clock; all flops rising-edge.
REQ-004 SHALL have port RstxRI, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port InxDI, input, SHARES*25*W, input state; share s at [s*25*W +: 25*W]; lane (x,y) at [(5x+y)*W +: W] within a share.
REQ-006 SHALL have port InValidxSI, input, 1, input valid.
REQ-007 SHALL have port InReadyxSO, output, 1, input ready; driven directly from a flop.
REQ-008 SHALL have port OutxDO, output, SHARES*25*W, output state, same layout as InxDI.
REQ-009 SHALL have port OutValidxSO, output, 1, output valid.
REQ-010 SHALL have port OutReadyxSI, input, 1, output ready.

Function
REQ-011 SHALL apply rho then pi to every share independently; there is no mixing between shares.
REQ-012 SHALL compute rho so that lane (x,y) is rotated left by r(x,y) mod W, where bit i moves to bit (i+r) mod W.
REQ-013 SHALL use the 64-bit Keccak offsets r(x,y): x=0: 0,36,3,41,18; x=1: 1,44,10,45,2; x=2: 62,6,43,15,61; x=3: 28,55,25,21,56; x=4: 27,20,39,8,14 (listed for y=0..4).
REQ-014 SHALL compute pi so that the rotated lane (x,y) is written to output lane (y,(2x+3y) mod 5).
REQ-015 SHALL register rho/pi results; latency is exactly 1 cycle from input handshake (InValidxSI & InReadyxSO) to OutValidxSO high, with no combinational path from InxDI to OutxDO.
REQ-016 SHALL buffer with a 2-entry skid; states EMPTY, ONE, FULL.
REQ-017 SHALL make these transitions: EMPTY --in--> ONE; ONE --in & !out--> FULL; ONE --out & !in--> EMPTY; ONE --in & out--> ONE; FULL --out--> ONE; FULL with no out stays FULL.
REQ-018 SHALL drive InReadyxSO high exactly in states EMPTY and ONE, and OutValidxSO high exactly in states ONE and FULL.
REQ-019 SHALL emit outputs in acceptance order and hold OutxDO stable while OutValidxSO & !OutReadyxSI.
REQ-020 SHALL treat a simultaneous input and output handshake in ONE as full throughput: 1 transfer per cycle, no bubble.
REQ-021 SHALL ignore InValidxSI while InReadyxSO is low; no data is lost or overwritten.

Reset
REQ-022 SHALL, while RstxRI is high at a clock edge, go to EMPTY with InReadyxSO=0, OutValidxSO=0 and OutxDO=0.
REQ-023 SHALL set InReadyxSO=1 in the first cycle after RstxRI deasserts.
REQ-024 SHALL discard all buffered entries on reset mid-operation, and emit no output produced from pre-reset data.

Configuration
REQ-025 SHALL, with macro KECCAK_RHOPI_INV_EN defined, add port InvxSI (input, 1), sampled with each accepted input and stored per entry; InvxSI=1 selects the inverse: pi^-1 (output lane (x,y) takes input lane (y,(2x+3y) mod 5)) followed by right rotation by r(x,y) mod W.
REQ-026 SHALL, without KECCAK_RHOPI_INV_EN, have no InvxSI port and no inverse datapath, and always perform forward rho/pi.

Structure
REQ-027 SHALL place the 25-entry 6-bit rotation-offset table, the lane-index function and the pi-destination function in package keccak_pkg.
REQ-028 SHALL use one combinational sub-module, keccak_rhopi_lane_perm (parameter W, one share); keccak_rhopi_pipe instantiates it SHARES times (twice per share when inverse is enabled).

Verification
REQ-029 SHALL cover: W=8, SHARES=1, only lane (1,0) bit0 set -> 1 cycle later only output lane (0,2) bit1 set.
REQ-030 SHALL cover: W=64, only lane (4,4) bit0 set -> only output lane (4,0) bit14 set; lane (0,0)=0x0123456789ABCDEF passes to lane (0,0) unchanged.
REQ-031 SHALL cover: SHARES=3, shares random A,B,C -> XOR of output shares equals rho/pi of A^B^C.
REQ-032 SHALL cover: OutReadyxSI low 4 cycles with InValidxSI held high -> exactly 2 accepted, InReadyxSO low from cycle 3, order kept after release; with OutReadyxSI and InValidxSI high continuously, 10 transfers take 10 cycles.
REQ-033 SHALL cover: RstxRI pulsed 1 cycle while FULL -> next cycle OutValidxSO=0 and InReadyxSO=0, then InReadyxSO=1; buffered data is never emitted.
REQ-034 SHALL cover, with KECCAK_RHOPI_INV_EN: a forward result fed back with InvxSI=1 returns the original state for 100 random states at W=16.

Source files
------------

// File: rtl/keccak_pkg.sv
// Keccak rho/pi shared definitions: skid states, rotation offsets,
// lane indexing and pi destination helpers.
package keccak_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } skid_e;

  // 64-bit rho offsets, entry 5x+y
  localparam logic [0:24][5:0] ROT_TAB = {
    6'd0,  6'd36, 6'd3,  6'd41, 6'd18,
    6'd1,  6'd44, 6'd10, 6'd45, 6'd2,
    6'd62, 6'd6,  6'd43, 6'd15, 6'd61,
    6'd28, 6'd55, 6'd25, 6'd21, 6'd56,
    6'd27, 6'd20, 6'd39, 6'd8,  6'd14
  };

  function automatic int lane_idx(input int x, input int y);
    return 5 * x + y;
  endfunction

  function automatic int pi_dst(input int x, input int y);
    return lane_idx(y, (2 * x + 3 * y) % 5);
  endfunction

endpackage

// File: rtl/keccak_rhopi_lane_perm.sv
// Combinational rho/pi (or inverse) over one 25-lane share.
// INV=1 builds pi^-1 followed by right rotation.
module keccak_rhopi_lane_perm
  import keccak_pkg::*;
#(
  parameter int W   = 8,
  parameter bit INV = 1'b0
) (
  input  logic [25*W-1:0] lanes,
  output logic [25*W-1:0] result
);

  for (genvar x = 0; x < 5; x++) begin : g_x
    for (genvar y = 0; y < 5; y++) begin : g_y
      localparam int S = lane_idx(x, y);
      localparam int D = pi_dst(x, y);
      localparam int R = int'(ROT_TAB[S]) % W;

      if (!INV) begin : g_fwd
        if (R == 0) begin : g_r0
          assign result[D*W +: W] = lanes[S*W +: W];
        end else begin : g_rot
          assign result[D*W +: W] =
            {lanes[S*W +: W-R], lanes[S*W+W-R +: R]};
        end
      end else begin : g_inv
        if (R == 0) begin : g_r0
          assign result[S*W +: W] = lanes[D*W +: W];
        end else begin : g_rot
          assign result[S*W +: W] =
            {lanes[D*W +: R], lanes[D*W+R +: W-R]};
        end
      end
    end
  end

endmodule

// File: rtl/keccak_rhopi_pipe.sv
// Masked Keccak rho/pi stage with a 2-entry registered skid buffer.
// Define KECCAK_RHOPI_INV_EN to add InvxSI and the inverse datapath.
module keccak_rhopi_pipe
  import keccak_pkg::*;
#(
  parameter int W      = 8,
  parameter int SHARES = 3
) (
  input  logic                   ClkxCI,
  input  logic                   RstxRI,
  input  logic [SHARES*25*W-1:0] InxDI,
`ifdef KECCAK_RHOPI_INV_EN
  input  logic                   InvxSI,
`endif
  input  logic                   InValidxSI,
  output logic                   InReadyxSO,
  output logic [SHARES*25*W-1:0] OutxDO,
  output logic                   OutValidxSO,
  input  logic                   OutReadyxSI
);

  localparam int SW = 25 * W;
  localparam int NB = SHARES * SW;

  logic [NB-1:0] fwd;
  logic [NB-1:0] perm;
  logic [NB-1:0] tail;
  skid_e         state;
  logic          in_hs;
  logic          out_hs;

  for (genvar s = 0; s < SHARES; s++) begin : g_fwd
    keccak_rhopi_lane_perm #(.W(W), .INV(1'b0)) u_perm (
      .lanes  (InxDI[s*SW +: SW]),
      .result (fwd[s*SW +: SW])
    );
  end

`ifdef KECCAK_RHOPI_INV_EN
  logic [NB-1:0] inv;

  for (genvar s = 0; s < SHARES; s++) begin : g_inv
    keccak_rhopi_lane_perm #(.W(W), .INV(1'b1)) u_perm (
      .lanes  (InxDI[s*SW +: SW]),
      .result (inv[s*SW +: SW])
    );
  end

  assign perm = InvxSI ? inv : fwd;
`else
  assign perm = fwd;
`endif

  assign in_hs  = InValidxSI & InReadyxSO;
  assign out_hs = OutValidxSO & OutReadyxSI;

  // OutxDO is the head entry; tail only fills while head stalls
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      state       <= EMPTY;
      InReadyxSO  <= 1'b0;
      OutValidxSO <= 1'b0;
      OutxDO      <= '0;
      tail        <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          InReadyxSO <= 1'b1;
          if (in_hs) begin
            OutxDO      <= perm;
            OutValidxSO <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (in_hs && out_hs) begin
            OutxDO <= perm;
          end else if (in_hs) begin
            tail       <= perm;
            InReadyxSO <= 1'b0;
            state      <= FULL;
          end else if (out_hs) begin
            OutValidxSO <= 1'b0;
            state       <= EMPTY;
          end
        end
        FULL: begin
          if (out_hs) begin
            OutxDO     <= tail;
            InReadyxSO <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          InReadyxSO  <= 1'b0;
          OutValidxSO <= 1'b0;
          state       <= EMPTY;
        end
      endcase
    end
  end

endmodule
